tlul_err_resp64: RTL and testbench

TLUL_ERR_RESP64 -- requirements
Module: tlul_err_resp64

---
 rtl/tlul_pkg.sv | 56 +++++
 rtl/tlul_err_resp64.sv | 75 +++++++
 tb/tb_tlul_err_resp64.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL 64-bit channel types, opcodes and constants.
package tlul_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 64;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_AUW = 16;
    localparam int TL_DUW = 8;

    localparam logic [TL_DW-1:0] TL_ERR_RESP_DATA64 = {TL_DW{1'b1}};

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef enum logic {
        ErrIdle,
        ErrResp
    } err_resp_state_e;

    // a_opcode is raw bits so illegal encodings can be carried and answered.
    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t64;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t64;
endpackage

// File: rtl/tlul_err_resp64.sv
// tlul_err_resp64: answers every TL-UL 64-bit request with an error response.
// Define TLUL_ERR_RESP64_CNT_EN to add a saturating count of accepted requests.
module tlul_err_resp64
    import tlul_pkg::*;
#(
    parameter logic [TL_DW-1:0] ErrRespData = TL_ERR_RESP_DATA64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
`ifdef TLUL_ERR_RESP64_CNT_EN
    input  logic       cnt_clr_i,
    output logic [15:0] err_cnt_o,
`endif
    input  tl_h2d_t64  tl_h2d_i,
    output tl_d2h_t64  tl_d2h_o
);
    err_resp_state_e state, state_next;
    logic [2:0]        op_q;
    logic [TL_AIW-1:0] source_q;
    logic [TL_SZW-1:0] size_q;
    logic              accept;
    logic              unused_fields;

    assign accept = (state == ErrIdle) && tl_h2d_i.a_valid;
    assign unused_fields = ^{tl_h2d_i.a_param, tl_h2d_i.a_address, tl_h2d_i.a_mask,
                             tl_h2d_i.a_data, tl_h2d_i.a_user};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ErrIdle;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept) state_next = ErrResp;
        else if (state == ErrResp && tl_h2d_i.d_ready) state_next = ErrIdle;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            source_q <= '0;
            size_q   <= '0;
        end else if (accept) begin
            op_q     <= tl_h2d_i.a_opcode;
            source_q <= tl_h2d_i.a_source;
            size_q   <= tl_h2d_i.a_size;
        end
    end

    // Outputs depend only on registered state, so a_ready never sees d_ready or a_valid.
    always_comb begin
        tl_d2h_o         = '0;
        tl_d2h_o.a_ready = (state == ErrIdle);
        if (state == ErrResp) begin
            tl_d2h_o.d_valid  = 1'b1;
            tl_d2h_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
            tl_d2h_o.d_size   = size_q;
            tl_d2h_o.d_source = source_q;
            tl_d2h_o.d_data   = ErrRespData;
            tl_d2h_o.d_error  = 1'b1;
        end
    end

`ifdef TLUL_ERR_RESP64_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_cnt_o <= '0;
        else if (cnt_clr_i) err_cnt_o <= '0;
        else if (accept && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end
`endif

    a_dvalid_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(tl_d2h_o.d_valid && tl_d2h_o.a_ready));
endmodule

// File: tb/tb_tlul_err_resp64.sv
// tb_tlul_err_resp64: directed table-driven bench for tlul_err_resp64.
module tb_tlul_err_resp64;
    import tlul_pkg::*;

    logic      clk_i = 1'b0;
    logic      rst_ni = 1'b0;
    tl_h2d_t64 h2d = '0;
    tl_d2h_t64 d2h;
    int        checks = 0;
    int        failures = 0;
    int        exp_cnt = 0;
`ifdef TLUL_ERR_RESP64_CNT_EN
    logic        cnt_clr_i = 1'b0;
    logic [15:0] err_cnt_o;
`endif

    tlul_err_resp64 dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
`ifdef TLUL_ERR_RESP64_CNT_EN
        .cnt_clr_i(cnt_clr_i),
        .err_cnt_o(err_cnt_o),
`endif
        .tl_h2d_i (h2d),
        .tl_d2h_o (d2h)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [2:0]  exp_op;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
`ifdef TLUL_ERR_RESP64_CNT_EN
        chk(name, 64'(err_cnt_o), 64'(exp_cnt));
`endif
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [7:0] src, input logic [1:0] size);
        h2d.a_valid  = 1'b1;
        h2d.a_opcode = op;
        h2d.a_source = src;
        h2d.a_size   = size;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rsp;
        vecs[0] = '{3'h4, 8'h05, 2'd3, 32'h0000_0000, 64'h0,                   8'hFF, 3'h1};
        vecs[1] = '{3'h0, 8'h02, 2'd3, 32'h0000_1000, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'h0};
        vecs[2] = '{3'h1, 8'hFF, 2'd0, 32'h0000_0003, 64'h0000_0000_0000_00A5, 8'h08, 3'h0};
        vecs[3] = '{3'h7, 8'h80, 2'd2, 32'hFFFF_FFFC, 64'hFFFF_0000_FFFF_0000, 8'hF0, 3'h0};
        vecs[4] = '{3'h2, 8'h11, 2'd1, 32'h1234_5678, 64'h5555_AAAA_5555_AAAA, 8'h0C, 3'h0};
        vecs[5] = '{3'h4, 8'h00, 2'd1, 32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3'h1};

        #12;
        chk("rst_a_ready", 64'(d2h.a_ready), 64'd1);
        chk("rst_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("rst_d_data", d2h.d_data, 64'd0);
        chk("rst_d_error", 64'(d2h.d_error), 64'd0);
        chk_cnt("rst_cnt");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk("vec_idle_a_ready", 64'(d2h.a_ready), 64'd1);
            chk("vec_idle_d_valid", 64'(d2h.d_valid), 64'd0);
            drive_req(vecs[i].op, vecs[i].src, vecs[i].size);
            h2d.a_address = vecs[i].addr;
            h2d.a_data    = vecs[i].data;
            h2d.a_mask    = vecs[i].mask;
            h2d.a_user    = 16'(i * 16'h1111);
            h2d.d_ready   = 1'b1;
            @(negedge clk_i);
            h2d.a_valid = 1'b0;
            exp_cnt++;
            chk("vec_d_valid", 64'(d2h.d_valid), 64'd1);
            chk("vec_a_ready", 64'(d2h.a_ready), 64'd0);
            chk("vec_d_opcode", 64'(d2h.d_opcode), 64'(vecs[i].exp_op));
            chk("vec_d_error", 64'(d2h.d_error), 64'd1);
            chk("vec_d_data", d2h.d_data, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("vec_d_source", 64'(d2h.d_source), 64'(vecs[i].src));
            chk("vec_d_size", 64'(d2h.d_size), 64'(vecs[i].size));
            chk("vec_zero_fields", 64'({d2h.d_sink, d2h.d_param, d2h.d_user}), 64'd0);
            @(negedge clk_i);
            chk("vec_done_d_valid", 64'(d2h.d_valid), 64'd0);
            chk("vec_done_d_error", 64'(d2h.d_error), 64'd0);
            chk("vec_done_payload", d2h.d_data | 64'(d2h.d_source) | 64'(d2h.d_opcode), 64'd0);
            chk_cnt("vec_cnt");
        end

        // Stall with d_ready low; a competing request must be ignored.
        @(negedge clk_i);
        drive_req(3'h0, 8'h02, 2'd2);
        h2d.d_ready = 1'b0;
        @(negedge clk_i);
        drive_req(3'h4, 8'h33, 2'd1);
        exp_cnt++;
        for (int k = 0; k < 10; k++) begin
            chk("stall_d_valid", 64'(d2h.d_valid), 64'd1);
            chk("stall_a_ready", 64'(d2h.a_ready), 64'd0);
            chk("stall_fields", {d2h.d_data[31:0], 13'd0, d2h.d_opcode, d2h.d_size, d2h.d_source, d2h.d_error},
                {32'hFFFF_FFFF, 13'd0, 3'h0, 2'd2, 8'h02, 1'b1});
            @(negedge clk_i);
        end
        h2d.a_valid = 1'b0;
        h2d.d_ready = 1'b1;
        chk("stall_last_d_valid", 64'(d2h.d_valid), 64'd1);
        @(negedge clk_i);
        chk("stall_done_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("stall_done_a_ready", 64'(d2h.a_ready), 64'd1);
        chk_cnt("stall_cnt");

        // Back-to-back a_valid over six cycles.
        acc = 0;
        rsp = 0;
        drive_req(3'h4, 8'h07, 2'd3);
        for (int k = 0; k < 6; k++) begin
            acc += int'(d2h.a_ready & h2d.a_valid);
            rsp += int'(d2h.d_valid);
            @(negedge clk_i);
        end
        h2d.a_valid = 1'b0;
        exp_cnt += 3;
        chk("b2b_accepted", 64'(acc), 64'd3);
        chk("b2b_responses", 64'(rsp), 64'd3);
        chk_cnt("b2b_cnt");

        // Reset while a response is pending.
        @(negedge clk_i);
        drive_req(3'h4, 8'h09, 2'd3);
        h2d.d_ready = 1'b0;
        @(negedge clk_i);
        h2d.a_valid = 1'b0;
        chk("rr_pre_d_valid", 64'(d2h.d_valid), 64'd1);
        #2 rst_ni = 1'b0;
        exp_cnt = 0;
        #1;
        chk("rr_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("rr_a_ready", 64'(d2h.a_ready), 64'd1);
        chk("rr_d_source", 64'(d2h.d_source), 64'd0);
        chk_cnt("rr_cnt");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rr_stale_d_valid", 64'(d2h.d_valid), 64'd0);
        chk("rr_post_a_ready", 64'(d2h.a_ready), 64'd1);

        // First edge after reset release accepts a request.
        rst_ni = 1'b0;
        @(negedge clk_i);
        drive_req(3'h4, 8'h4C, 2'd2);
        h2d.d_ready = 1'b1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        h2d.a_valid = 1'b0;
        exp_cnt = 1;
        chk("rel_d_valid", 64'(d2h.d_valid), 64'd1);
        chk("rel_d_source", 64'(d2h.d_source), 64'h4C);
        chk("rel_d_opcode", 64'(d2h.d_opcode), 64'(AccessAckData));
        @(negedge clk_i);
        chk("rel_done_d_valid", 64'(d2h.d_valid), 64'd0);
        chk_cnt("rel_cnt");

`ifdef TLUL_ERR_RESP64_CNT_EN
        // Saturation and clear priority, starting near the top of the range.
        force dut.err_cnt_o = 16'hFFFE;
        @(negedge clk_i);
        release dut.err_cnt_o;
        @(negedge clk_i);
        chk("sat_preload", 64'(err_cnt_o), 64'hFFFE);
        for (int k = 0; k < 2; k++) begin
            drive_req(3'h0, 8'h01, 2'd0);
            @(negedge clk_i);
            h2d.a_valid = 1'b0;
            @(negedge clk_i);
        end
        chk("sat_hold", 64'(err_cnt_o), 64'hFFFF);
        drive_req(3'h0, 8'h01, 2'd0);
        cnt_clr_i = 1'b1;
        @(negedge clk_i);
        h2d.a_valid = 1'b0;
        cnt_clr_i = 1'b0;
        chk("clr_priority", 64'(err_cnt_o), 64'd0);
        chk("clr_d_valid", 64'(d2h.d_valid), 64'd1);
        @(negedge clk_i);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
